lru_cam: RTL and testbench

LRU_CAM -- requirements
Module: lru_cam

---
 rtl/lru_cam.sv | 139 +++++++++++++
 tb/tb_lru_cam.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lru_cam.sv
// lru_cam: fully associative key CAM with true-LRU replacement and a 1-cycle registered response.
// Build macro CAM_MASK_EN adds op_mask, a per-bit don't-care mask applied to lookups only.
module lru_cam #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic                  op_we,
    input  logic [WIDTH-1:0]      op_key,
`ifdef CAM_MASK_EN
    input  logic [WIDTH-1:0]      op_mask,
`endif
    input  logic                  clear,
    output logic                  rsp_valid,
    output logic                  match,
    output logic [ADDR_WIDTH-1:0] match_addr,
    output logic                  evict,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [DEPTH-1:0]      valid_q;
    logic [WIDTH-1:0]      keys_q [DEPTH];
    logic [ADDR_WIDTH-1:0] age_q  [DEPTH];

    logic [WIDTH-1:0]      cmp_mask_c;
    logic [DEPTH-1:0]      hit_vec_c;
    logic                  hit_c;
    logic [ADDR_WIDTH-1:0] hit_idx_c;
    logic [ADDR_WIDTH-1:0] free_idx_c;
    logic [ADDR_WIDTH-1:0] victim_idx_c;
    logic                  accept_c;
    logic                  do_insert_c;
    logic                  do_touch_c;
    logic [ADDR_WIDTH-1:0] tgt_idx_c;
    logic [CW-1:0]         thresh_c;

    // Parallel compare; inserts always compare the full key.
    always_comb begin
        cmp_mask_c = '0;
`ifdef CAM_MASK_EN
        if (!op_we) begin
            cmp_mask_c = op_mask;
        end
`endif
        for (int i = 0; i < int'(DEPTH); i++) begin
            hit_vec_c[i] = valid_q[i] && (((keys_q[i] ^ op_key) & ~cmp_mask_c) == '0);
        end
    end

    // Lowest-index priority encoders for hit and free slot; victim is the entry aged DEPTH-1.
    always_comb begin
        hit_c        = |hit_vec_c;
        hit_idx_c    = '0;
        free_idx_c   = '0;
        victim_idx_c = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (hit_vec_c[i]) begin
                hit_idx_c = ADDR_WIDTH'(i);
            end
            if (!valid_q[i]) begin
                free_idx_c = ADDR_WIDTH'(i);
            end
            if (valid_q[i] && (age_q[i] == ADDR_WIDTH'(DEPTH - 1))) begin
                victim_idx_c = ADDR_WIDTH'(i);
            end
        end
    end

    // Every state change is a touch of tgt: entries younger than thresh age by one, tgt becomes MRU.
    always_comb begin
        accept_c    = op_valid && !clear;
        do_insert_c = accept_c && op_we && !hit_c;
        do_touch_c  = accept_c && (hit_c || op_we);
        tgt_idx_c   = free_idx_c;
        thresh_c    = count;
        if (hit_c) begin
            tgt_idx_c = hit_idx_c;
            thresh_c  = {1'b0, age_q[hit_idx_c]};
        end else if (full) begin
            tgt_idx_c = victim_idx_c;
            thresh_c  = CW'(DEPTH - 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            rsp_valid  <= 1'b0;
            match      <= 1'b0;
            match_addr <= '0;
            evict      <= 1'b0;
            full       <= 1'b0;
            count      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                keys_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else if (clear) begin
            valid_q   <= '0;
            rsp_valid <= 1'b0;
            full      <= 1'b0;
            count     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                age_q[i] <= '0;
            end
        end else begin
            rsp_valid <= op_valid;
            if (op_valid) begin
                match      <= hit_c;
                evict      <= do_insert_c && full;
                match_addr <= (hit_c || op_we) ? tgt_idx_c : '0;
            end
            if (do_touch_c) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (ADDR_WIDTH'(i) == tgt_idx_c) begin
                        age_q[i] <= '0;
                    end else if (valid_q[i] && ({1'b0, age_q[i]} < thresh_c)) begin
                        age_q[i] <= age_q[i] + ADDR_WIDTH'(1);
                    end
                end
            end
            if (do_insert_c) begin
                keys_q[tgt_idx_c]  <= op_key;
                valid_q[tgt_idx_c] <= 1'b1;
                if (!full) begin
                    count <= count + CW'(1);
                    full  <= ((count + CW'(1)) == CW'(DEPTH));
                end
            end
        end
    end

endmodule

// File: tb/tb_lru_cam.sv
// tb_lru_cam: directed vector table, reset/clear corner sequences and a random run against an MRU-list model.
module tb_lru_cam;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid;
    logic       op_we;
    logic [7:0] op_key;
`ifdef CAM_MASK_EN
    logic [7:0] op_mask;
`endif
    logic       clear;
    logic       rsp_valid;
    logic       match;
    logic [3:0] match_addr;
    logic       evict;
    logic       full;
    logic [4:0] count;

    lru_cam #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_we(op_we), .op_key(op_key),
`ifdef CAM_MASK_EN
        .op_mask(op_mask),
`endif
        .clear(clear), .rsp_valid(rsp_valid), .match(match), .match_addr(match_addr),
        .evict(evict), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       we;
        logic       clr;
        logic [7:0] key;
        logic [7:0] mask;
        logic       m;
        logic [3:0] a;
        logic       e;
        logic [4:0] cnt;
        logic       fl;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t sb_q[$];
    vec_t vecs[$];
    logic       hold_m = 1'b0;
    logic [3:0] hold_a = 4'd0;
    logic       hold_e = 1'b0;

    // Reference model: slot contents plus a recency list, front = MRU.
    logic [7:0] m_key [16];
    logic       m_val [16];
    int         m_order[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic we, input logic clr, input logic [7:0] key,
                                input logic m, input logic [3:0] a, input logic e,
                                input logic [4:0] cnt, input logic fl);
        vec_t t;
        t.v = v; t.we = we; t.clr = clr; t.key = key; t.mask = 8'h00;
        t.m = m; t.a = a; t.e = e; t.cnt = cnt; t.fl = fl;
        return t;
    endfunction

    task automatic check_out(input logic [4:0] cnt, input logic fl);
        vec_t r;
        chk("rsp_valid", 32'(rsp_valid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            r = sb_q.pop_front();
            hold_m = r.m; hold_a = r.a; hold_e = r.e;
        end
        chk("match", 32'(match), 32'(hold_m));
        chk("match_addr", 32'(match_addr), 32'(hold_a));
        chk("evict", 32'(evict), 32'(hold_e));
        chk("count", 32'(count), 32'(cnt));
        chk("full", 32'(full), 32'(fl));
    endtask

    task automatic cycle(input vec_t t);
        op_valid = t.v; op_we = t.we; op_key = t.key; clear = t.clr;
`ifdef CAM_MASK_EN
        op_mask = t.mask;
`endif
        if (t.v && !t.clr) sb_q.push_back(t);
        @(posedge clk); #1;
        check_out(t.cnt, t.fl);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
        m_order.delete();
    endtask

    task automatic model_touch(input int idx);
        int pos;
        pos = 0;
        for (int j = 0; j < m_order.size(); j++) if (m_order[j] == idx) pos = j;
        m_order.delete(pos);
        m_order.push_front(idx);
    endtask

    task automatic model_op(input logic we, input logic [7:0] key,
                            output logic m, output logic [3:0] a, output logic e);
        int hit;
        int slot;
        hit = -1; m = 1'b0; a = 4'd0; e = 1'b0;
        for (int i = 0; i < 16; i++) if (hit < 0 && m_val[i] && m_key[i] == key) hit = i;
        if (hit >= 0) begin
            m = 1'b1; a = 4'(hit);
            model_touch(hit);
        end else if (we) begin
            if (m_order.size() < 16) begin
                slot = -1;
                for (int i = 0; i < 16; i++) if (slot < 0 && !m_val[i]) slot = i;
            end else begin
                slot = m_order.pop_back();
                e = 1'b1;
            end
            m_val[slot] = 1'b1;
            m_key[slot] = key;
            m_order.push_front(slot);
            a = 4'(slot);
        end
    endtask

    initial begin
        logic       rm;
        logic [3:0] ra;
        logic       re;
        int         r;
        vec_t       t;

        reset = 1'b0; op_valid = 1'b0; op_we = 1'b0; op_key = 8'h00; clear = 1'b0;
`ifdef CAM_MASK_EN
        op_mask = 8'h00;
`endif
        model_clear();

        // Directed table.
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'd0, 0, 5'd0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 1, 0, 8'(8'h10 + i), 0, 4'(i), 0, 5'(i + 1), i == 15));
        vecs.push_back(mk(1, 1, 0, 8'h10, 1, 4'd0, 0, 5'd16, 1));
        vecs.push_back(mk(1, 0, 0, 8'h10, 1, 4'd0, 0, 5'd16, 1));
        vecs.push_back(mk(1, 1, 0, 8'h55, 0, 4'd1, 1, 5'd16, 1));
        vecs.push_back(mk(1, 0, 0, 8'h11, 0, 4'd0, 0, 5'd16, 1));
        vecs.push_back(mk(1, 0, 0, 8'h55, 1, 4'd1, 0, 5'd16, 1));
        vecs.push_back(mk(1, 1, 0, 8'h66, 0, 4'd2, 1, 5'd16, 1));
        vecs.push_back(mk(1, 0, 0, 8'h12, 0, 4'd0, 0, 5'd16, 1));
        vecs.push_back(mk(1, 0, 0, 8'h13, 1, 4'd3, 0, 5'd16, 1));
        vecs.push_back(mk(1, 1, 0, 8'h77, 0, 4'd4, 1, 5'd16, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 4'd0, 0, 5'd16, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 4'd0, 0, 5'd0, 0));
        vecs.push_back(mk(1, 1, 0, 8'hA1, 0, 4'd0, 0, 5'd1, 0));
        vecs.push_back(mk(1, 1, 0, 8'hA2, 0, 4'd1, 0, 5'd2, 0));
        vecs.push_back(mk(1, 1, 0, 8'hA3, 0, 4'd2, 0, 5'd3, 0));
        vecs.push_back(mk(1, 1, 1, 8'h77, 0, 4'd0, 0, 5'd0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h77, 0, 4'd0, 0, 5'd0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h77, 0, 4'd0, 0, 5'd1, 0));
        vecs.push_back(mk(1, 1, 0, 8'h77, 1, 4'd0, 0, 5'd1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 4'd0, 0, 5'd1, 0));

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_out(5'd0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) cycle(vecs[i]);

        // Reset pulse with an operation in flight.
        cycle(mk(1, 1, 0, 8'h88, 0, 4'd1, 0, 5'd2, 0));
        op_valid = 1'b1; op_we = 1'b1; op_key = 8'h99; clear = 1'b0;
        #2 reset = 1'b0;
        #1;
        sb_q.delete();
        hold_m = 1'b0; hold_a = 4'd0; hold_e = 1'b0;
        check_out(5'd0, 1'b0);
        @(posedge clk); #1;
        check_out(5'd0, 1'b0);
        reset = 1'b1;
        cycle(mk(1, 1, 0, 8'h99, 0, 4'd0, 0, 5'd1, 0));
        cycle(mk(1, 0, 0, 8'h88, 0, 4'd0, 0, 5'd1, 0));
        cycle(mk(1, 0, 0, 8'h99, 1, 4'd0, 0, 5'd1, 0));

        // Random traffic against the model; a small key space forces hits and evictions.
        cycle(mk(0, 0, 1, 8'h00, 0, 4'd0, 0, 5'd0, 0));
        model_clear();
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            t = mk(r < 90, 1'($urandom_range(0, 1)), r < 3, 8'($urandom_range(0, 21)),
                   0, 4'd0, 0, 5'd0, 0);
            if (t.clr) begin
                model_clear();
            end else if (t.v) begin
                model_op(t.we, t.key, rm, ra, re);
                t.m = rm; t.a = ra; t.e = re;
            end
            t.cnt = 5'(m_order.size());
            t.fl  = (m_order.size() == 16);
            cycle(t);
        end

`ifdef CAM_MASK_EN
        cycle(mk(0, 0, 1, 8'h00, 0, 4'd0, 0, 5'd0, 0));
        cycle(mk(1, 1, 0, 8'hA5, 0, 4'd0, 0, 5'd1, 0));
        t = mk(1, 0, 0, 8'hAF, 1, 4'd0, 0, 5'd1, 0); t.mask = 8'h0F; cycle(t);
        t = mk(1, 1, 0, 8'hAF, 0, 4'd1, 0, 5'd2, 0); t.mask = 8'h0F; cycle(t);
        t = mk(1, 0, 0, 8'hA0, 1, 4'd0, 0, 5'd2, 0); t.mask = 8'h0F; cycle(t);
        cycle(mk(1, 0, 0, 8'hAF, 1, 4'd1, 0, 5'd2, 0));
`endif

        op_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
